// File: rtl/vector_bank_pkg.sv
// vector_bank_pkg
//   Shared constants and types for the parameterised vector bank.
//   DEF_WIDTH / DEF_LANES / DEF_DEPTH : default geometry of the bank
//   lane_vec_t                        : one vector at default geometry,
//                                       lane 0 in the least significant bits
package vector_bank_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_DEPTH = 8;

  typedef logic [DEF_LANES-1:0][DEF_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/bank_ptr_ctrl.sv
// bank_ptr_ctrl
//   Append pointer, fill count, full flag and sticky overflow flag for
//   param_vector_bank.
//   clk, rst   : clock, asynchronous active-high reset
//   append_i   : append request (write strobe qualified with append)
//   clear_i    : synchronous clear of pointer, count and overflow
//   accept_o   : the append request performs a write this cycle
//   wptr_o     : next append index
//   count_o    : number of appended entries, saturates at DEPTH
//   full_o     : count_o == DEPTH
//   overflow_o : sticky, set when an append is dropped while full
module bank_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       append_i,
  input  logic                       clear_i,
  output logic                       accept_o,
  output logic [$clog2(DEPTH)-1:0]   wptr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       overflow_o
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wrap_en;

  assign wrap_en = (WRAP != 0);
  assign full_o  = (count_q == CNT_MAX);

  // Clear wins over an append; a full bank only takes appends when wrapping.
  assign accept_o = append_i & ~clear_i & (~full_o | wrap_en);

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      wptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (append_i) begin
      if (accept_o) begin
        // DEPTH is a power of two, so the pointer wraps by natural rollover.
        wptr_d = wptr_q + 1'b1;
        if (!full_o) count_d = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wptr_o     = wptr_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/param_vector_bank.sv
// param_vector_bank
//   DEPTH-entry bank of LANES x WIDTH vectors with per-lane masked writes,
//   addressed or append-mode writes, two registered read ports with
//   write-through, and append pointer / count / full / overflow status.
//   clk, rst           : clock, asynchronous active-high reset (clears array)
//   we, append         : write strobe; append=1 writes at wptr, else at waddr
//   waddr              : addressed-write index
//   lane_mask, wdata   : per-lane write enable and write vector
//   raddr_a/b          : read indices, data returned one cycle later
//   rdata_a/b          : registered read vectors
//   clear              : synchronous clear of wptr/count/overflow
//   wptr, count, full, overflow : append status
module param_vector_bank
  import vector_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WRAP  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          append,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [LANES-1:0]              lane_mask,
  input  logic [LANES-1:0][WIDTH-1:0]   wdata,
  input  logic [$clog2(DEPTH)-1:0]      raddr_a,
  input  logic [$clog2(DEPTH)-1:0]      raddr_b,
  output logic [LANES-1:0][WIDTH-1:0]   rdata_a,
  output logic [LANES-1:0][WIDTH-1:0]   rdata_b,
  input  logic                          clear,
  output logic [$clog2(DEPTH)-1:0]      wptr,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  vec_t          mem_q [DEPTH];
  vec_t          rdata_a_q, rdata_b_q, rd_a_d, rd_b_d;
  logic          app_accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  bank_ptr_ctrl #(
    .DEPTH (DEPTH),
    .WRAP  (WRAP)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .append_i   (we & append),
    .clear_i    (clear),
    .accept_o   (app_accept),
    .wptr_o     (wptr),
    .count_o    (count),
    .full_o     (full),
    .overflow_o (overflow)
  );

  // Addressed writes are never gated by clear or by the full state.
  assign wr_en   = we & (append ? app_accept : 1'b1);
  assign wr_addr = append ? wptr : waddr;

  // Read mux with write-through of the lanes being written this cycle.
  always_comb begin
    rd_a_d = mem_q[raddr_a];
    rd_b_d = mem_q[raddr_b];
    for (int l = 0; l < LANES; l++) begin
      if (wr_en && lane_mask[l]) begin
        if (raddr_a == wr_addr) rd_a_d[l] = wdata[l];
        if (raddr_b == wr_addr) rd_b_d[l] = wdata[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (wr_en) begin
        for (int l = 0; l < LANES; l++)
          if (lane_mask[l]) mem_q[wr_addr][l] <= wdata[l];
      end
      rdata_a_q <= rd_a_d;
      rdata_b_q <= rd_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_param_vector_bank.sv
// tb_param_vector_bank
//   Drives a WRAP=0 and a WRAP=1 bank with identical stimulus: a table of
//   directed vectors, hand-written corner sequences, then random traffic,
//   all compared against a behavioural model of the bank.
module tb_param_vector_bank;
  import vector_bank_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int L  = DEF_LANES;
  localparam int D  = DEF_DEPTH;
  localparam int AW = $clog2(D);

  logic            clk = 1'b0;
  logic            rst;
  logic            we, append, clear;
  logic [AW-1:0]   waddr, raddr_a, raddr_b;
  logic [L-1:0]    lane_mask;
  lane_vec_t       wdata;
  lane_vec_t       rda [2];
  lane_vec_t       rdb [2];
  logic [AW-1:0]   wptr_o [2];
  logic [AW:0]     count_o [2];
  logic            full_o [2];
  logic            ovf_o [2];

  always #5 clk = ~clk;

  param_vector_bank #(.WIDTH(W), .LANES(L), .DEPTH(D), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .append(append), .waddr(waddr),
    .lane_mask(lane_mask), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rda[0]), .rdata_b(rdb[0]), .clear(clear), .wptr(wptr_o[0]),
    .count(count_o[0]), .full(full_o[0]), .overflow(ovf_o[0]));

  param_vector_bank #(.WIDTH(W), .LANES(L), .DEPTH(D), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .append(append), .waddr(waddr),
    .lane_mask(lane_mask), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rda[1]), .rdata_b(rdb[1]), .clear(clear), .wptr(wptr_o[1]),
    .count(count_o[1]), .full(full_o[1]), .overflow(ovf_o[1]));

  // ---------------- behavioural model ----------------
  int unsigned mm   [2][D][L];
  int unsigned m_ra [2][L];
  int unsigned m_rb [2][L];
  int          m_wptr [2];
  int          m_cnt  [2];
  bit          m_ovf  [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic lane_vec_t vec4(input int unsigned l0, l1, l2, l3);
    lane_vec_t v;
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wptr[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      for (int l = 0; l < L; l++) begin m_ra[k][l] = 0; m_rb[k][l] = 0; end
      for (int e = 0; e < D; e++)
        for (int l = 0; l < L; l++) mm[k][e][l] = 0;
    end
  endtask

  // One clock of the bank as described in words: k=1 is the wrapping bank.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit do_wr;
      int a;
      do_wr = 0;
      a = 0;
      if (we && !append) begin
        do_wr = 1; a = int'(waddr);
      end else if (we && append && !clear) begin
        if (m_cnt[k] < D || k == 1) begin
          do_wr = 1; a = m_wptr[k];
          m_wptr[k] = (m_wptr[k] + 1) % D;
          if (m_cnt[k] < D) m_cnt[k]++;
        end else begin
          m_ovf[k] = 1;
        end
      end
      for (int l = 0; l < L; l++) begin
        m_ra[k][l] = (do_wr && a == int'(raddr_a) && lane_mask[l]) ? wdata[l] : mm[k][raddr_a][l];
        m_rb[k][l] = (do_wr && a == int'(raddr_b) && lane_mask[l]) ? wdata[l] : mm[k][raddr_b][l];
      end
      if (do_wr)
        for (int l = 0; l < L; l++) if (lane_mask[l]) mm[k][a][l] = wdata[l];
      if (clear) begin m_wptr[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; end
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      lane_vec_t ea, eb;
      for (int l = 0; l < L; l++) begin ea[l] = m_ra[k][l]; eb[l] = m_rb[k][l]; end
      chk($sformatf("dut%0d.wptr", k), wptr_o[k], m_wptr[k]);
      chk($sformatf("dut%0d.count", k), count_o[k], m_cnt[k]);
      chk($sformatf("dut%0d.full", k), full_o[k], (m_cnt[k] == D));
      chk($sformatf("dut%0d.overflow", k), ovf_o[k], m_ovf[k]);
      chk($sformatf("dut%0d.rdata_a", k), rda[k], ea);
      chk($sformatf("dut%0d.rdata_b", k), rdb[k], eb);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_idle();
    we = 0; append = 0; clear = 0; waddr = '0; raddr_a = '0; raddr_b = '0;
    lane_mask = '0; wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d.wptr", tag, k), wptr_o[k], 0);
      chk($sformatf("%s dut%0d.count", tag, k), count_o[k], 0);
      chk($sformatf("%s dut%0d.full", tag, k), full_o[k], 0);
      chk($sformatf("%s dut%0d.overflow", tag, k), ovf_o[k], 0);
      chk($sformatf("%s dut%0d.rdata_a", tag, k), rda[k], 0);
      chk($sformatf("%s dut%0d.rdata_b", tag, k), rdb[k], 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic append_val(input int unsigned v);
    we = 1; append = 1; clear = 0; lane_mask = 4'hF; wdata = vec4(v, v, v, v);
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        we, app, clr;
    int        waddr, ra, rb;
    bit [3:0]  mask;
    lane_vec_t d, ea, eb;
    int        ewptr, ecnt;
  } vec_rec_t;

  vec_rec_t tbl [7];

  task automatic set_rec(input int i, input bit we_v, app_v, input int wa, ra, rb,
                         input bit [3:0] m, input lane_vec_t d, ea, eb, input int ewp, ec);
    tbl[i].we = we_v; tbl[i].app = app_v; tbl[i].clr = 0;
    tbl[i].waddr = wa; tbl[i].ra = ra; tbl[i].rb = rb; tbl[i].mask = m;
    tbl[i].d = d; tbl[i].ea = ea; tbl[i].eb = eb; tbl[i].ewptr = ewp; tbl[i].ecnt = ec;
  endtask

  initial begin
    lane_vec_t v0, v3;
    v0 = vec4(15, 45, 74, 82);
    v3 = vec4(16, 0, 75, 0);
    set_rec(0, 1, 1, 0, 0, 1, 4'hF, v0,                 v0,               '0,              1, 1);
    set_rec(1, 0, 0, 0, 0, 3, 4'h0, '0,                 v0,               '0,              1, 1);
    set_rec(2, 1, 0, 3, 3, 0, 4'h5, vec4(16,46,75,83),  v3,               v0,              1, 1);
    set_rec(3, 0, 0, 0, 3, 3, 4'h0, '0,                 v3,               v3,              1, 1);
    set_rec(4, 1, 0, 2, 2, 1, 4'hF, vec4(5,5,5,5),      vec4(5,5,5,5),    '0,              1, 1);
    set_rec(5, 1, 0, 2, 0, 2, 4'h3, vec4(7,7,7,7),      v0,               vec4(7,7,5,5),   1, 1);
    set_rec(6, 1, 1, 0, 1, 1, 4'h0, vec4(99,99,99,99),  '0,               '0,              2, 2);

    set_idle();
    rst = 1;
    model_reset();
    #2;
    check_all_zero("por");
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      we = tbl[i].we; append = tbl[i].app; clear = tbl[i].clr;
      waddr = AW'(tbl[i].waddr); raddr_a = AW'(tbl[i].ra); raddr_b = AW'(tbl[i].rb);
      lane_mask = tbl[i].mask; wdata = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d rdata_a", i), rda[0], tbl[i].ea);
      chk($sformatf("tbl%0d rdata_b", i), rdb[0], tbl[i].eb);
      chk($sformatf("tbl%0d wptr", i), wptr_o[0], tbl[i].ewptr);
      chk($sformatf("tbl%0d count", i), count_o[0], tbl[i].ecnt);
    end

    // clear together with an append after three appends
    do_reset();
    for (int v = 1; v <= 3; v++) append_val(v);
    we = 1; append = 1; clear = 1; lane_mask = 4'hF; wdata = vec4(77, 77, 77, 77);
    raddr_a = 3;
    tick();
    chk("clr wptr", wptr_o[0], 0);
    chk("clr count", count_o[0], 0);
    chk("clr rdata_a entry3", rda[0], 0);
    set_idle(); raddr_a = 3; raddr_b = 2;
    tick();
    chk("clr entry3 untouched", rda[0], 0);
    chk("clr entry2 kept", rdb[0], vec4(3, 3, 3, 3));

    // reset asserted mid-cycle with an append pending
    we = 1; append = 1; lane_mask = 4'hF; wdata = vec4(55, 55, 55, 55);
    #2;
    rst = 1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 0;
    tick();
    chk("post-rst wptr", wptr_o[0], 1);
    set_idle(); raddr_a = 0; raddr_b = 1;
    tick();
    chk("post-rst entry0", rda[0], vec4(55, 55, 55, 55));

    // nine appends into an eight-deep bank
    do_reset();
    for (int v = 1; v <= 9; v++) append_val(v);
    set_idle(); raddr_a = 0;
    tick();
    chk("nowrap count", count_o[0], 8);
    chk("nowrap full", full_o[0], 1);
    chk("nowrap overflow", ovf_o[0], 1);
    chk("nowrap wptr", wptr_o[0], 0);
    chk("nowrap entry0", rda[0], vec4(1, 1, 1, 1));
    chk("wrap count", count_o[1], 8);
    chk("wrap overflow", ovf_o[1], 0);
    chk("wrap wptr", wptr_o[1], 1);
    chk("wrap entry0", rda[1], vec4(9, 9, 9, 9));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom % 4) != 0;
      append    = $urandom % 2;
      clear     = ($urandom % 16) == 0;
      waddr     = AW'($urandom);
      raddr_a   = AW'($urandom);
      raddr_b   = ($urandom % 3 == 0) ? waddr : AW'($urandom);
      lane_mask = L'($urandom);
      for (int l = 0; l < L; l++) wdata[l] = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
